// File: rtl/lemming_world.sv
// Lemming walker world: tracks the walker's cell, the hole map and the fall count.
// Holes are filled on the landing edge of a fall; completed falls are counted.
module lemming_world #(
  parameter int FALL_DEPTH = 4
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        walk_left,
  input  logic        walk_right,
  input  logic        aaah,
  input  logic        step_en,
  input  logic        load,
  input  logic [15:0] map_in,
  output logic        ground,
  output logic        turn_left,
  output logic        turn_right,
  output logic [3:0]  pos,
  output logic [7:0]  falls,
  output logic        done
);

  localparam logic [3:0] DEPTH    = 4'(FALL_DEPTH);
  localparam logic [3:0] DEPTH_M1 = 4'(FALL_DEPTH - 1);
  localparam logic [3:0] POS_MAX  = 4'd15;
  localparam logic [7:0] FALL_MAX = 8'd255;

  logic [15:0] holes;
  logic [3:0]  fall_cnt;
  logic        landing;
  logic        move_left;
  logic        move_right;

  // The landing edge is the last cycle of a fall; the hole under the walker is filled then.
  assign landing    = aaah && (fall_cnt == DEPTH_M1);
  assign move_left  = step_en && walk_left && !walk_right && (pos != 4'd0);
  assign move_right = step_en && walk_right && !walk_left && (pos != POS_MAX);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pos      <= 4'd0;
      holes    <= 16'h0000;
      fall_cnt <= 4'd0;
      falls    <= 8'd0;
    end else if (load) begin
      holes    <= map_in;
      pos      <= 4'd0;
      fall_cnt <= 4'd0;
    end else if (aaah) begin
      if (fall_cnt != DEPTH) begin
        fall_cnt <= fall_cnt + 4'd1;
      end
      if (landing) begin
        holes[pos] <= 1'b0;
        if (falls != FALL_MAX) begin
          falls <= falls + 8'd1;
        end
      end
    end else begin
      fall_cnt <= 4'd0;
      if (move_left) begin
        pos <= pos - 4'd1;
      end else if (move_right) begin
        pos <= pos + 4'd1;
      end
    end
  end

  // While falling, ground reappears on the landing cycle; otherwise it is the map under the walker.
  assign ground     = aaah ? (fall_cnt >= DEPTH_M1) : ~holes[pos];
  assign turn_right = walk_left  && !aaah && (pos == 4'd0);
  assign turn_left  = walk_right && !aaah && (pos == POS_MAX);
  assign done       = (holes == 16'h0000);

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world: one instance with the default fall depth
// and one with a single-cycle fall for the depth-1 and saturation cases.
module tb_lemming_world;

  logic        clk;
  logic        areset_n;

  logic        walk_left, walk_right, aaah, step_en, load;
  logic [15:0] map_in;
  logic        ground, turn_left, turn_right, done;
  logic [3:0]  pos;
  logic [7:0]  falls;

  logic        d1_walk_left, d1_walk_right, d1_aaah, d1_step_en, d1_load;
  logic [15:0] d1_map_in;
  logic        d1_ground, d1_turn_left, d1_turn_right, d1_done;
  logic [3:0]  d1_pos;
  logic [7:0]  d1_falls;

  int n_checks = 0;
  int n_errors = 0;

  lemming_world #(.FALL_DEPTH(4)) u_dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .step_en    (step_en),
    .load       (load),
    .map_in     (map_in),
    .ground     (ground),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .pos        (pos),
    .falls      (falls),
    .done       (done)
  );

  lemming_world #(.FALL_DEPTH(1)) u_dut1 (
    .clk        (clk),
    .areset_n   (areset_n),
    .walk_left  (d1_walk_left),
    .walk_right (d1_walk_right),
    .aaah       (d1_aaah),
    .step_en    (d1_step_en),
    .load       (d1_load),
    .map_in     (d1_map_in),
    .ground     (d1_ground),
    .turn_left  (d1_turn_left),
    .turn_right (d1_turn_right),
    .pos        (d1_pos),
    .falls      (d1_falls),
    .done       (d1_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are checked 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_walk(input logic l, input logic r, input logic s);
    walk_left  = l;
    walk_right = r;
    step_en    = s;
  endtask

  task automatic load_map(input logic [15:0] m);
    load   = 1'b1;
    map_in = m;
    tick();
    load   = 1'b0;
  endtask

  // One complete single-cycle fall on the depth-1 instance into a hole at cell 0.
  task automatic d1_fall();
    d1_load   = 1'b1;
    d1_map_in = 16'h0001;
    tick();
    d1_load   = 1'b0;
    d1_aaah   = 1'b1;
    tick();
    d1_aaah   = 1'b0;
  endtask

  initial begin
    areset_n = 1'b0;
    set_walk(1'b0, 1'b0, 1'b0);
    aaah = 1'b0; load = 1'b0; map_in = 16'h0000;
    d1_walk_left = 1'b0; d1_walk_right = 1'b0; d1_aaah = 1'b0;
    d1_step_en = 1'b0; d1_load = 1'b0; d1_map_in = 16'h0000;
    #12;
    check("reset_pos", 16'(pos), 16'd0);
    check("reset_falls", 16'(falls), 16'd0);
    check("reset_ground", 16'(ground), 16'd1);
    check("reset_done", 16'(done), 16'd1);
    tick();
    areset_n = 1'b1;
    tick();

    // Walking left into the left wall
    load_map(16'h0000);
    set_walk(1'b1, 1'b0, 1'b1);
    #1;
    check("left_wall_turn_right", 16'(turn_right), 16'd1);
    check("left_wall_turn_left", 16'(turn_left), 16'd0);
    tick();
    tick();
    check("left_wall_pos", 16'(pos), 16'd0);
    check("left_wall_turn_right_hold", 16'(turn_right), 16'd1);

    // Walking right to the right wall
    load_map(16'h0000);
    set_walk(1'b0, 1'b1, 1'b1);
    tick();
    check("right_walk_pos1", 16'(pos), 16'd1);
    check("right_walk_no_turn", 16'(turn_left), 16'd0);
    for (int i = 0; i < 14; i++) tick();
    check("right_wall_pos", 16'(pos), 16'd15);
    check("right_wall_turn_left", 16'(turn_left), 16'd1);
    check("right_wall_turn_right", 16'(turn_right), 16'd0);
    tick();
    check("right_wall_pos_hold", 16'(pos), 16'd15);
    set_walk(1'b1, 1'b1, 1'b1);
    tick();
    check("both_walk_no_move", 16'(pos), 16'd15);

    // Hole at cell 3, four-cycle fall
    set_walk(1'b0, 1'b0, 1'b0);
    load_map(16'h0008);
    check("hole_load_pos", 16'(pos), 16'd0);
    check("hole_load_done", 16'(done), 16'd0);
    set_walk(1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("hole_pos", 16'(pos), 16'd3);
    check("hole_ground", 16'(ground), 16'd0);
    aaah = 1'b1;
    #1;
    check("fall_c0_ground", 16'(ground), 16'd0);
    check("fall_c0_no_turn", 16'(turn_left), 16'd0);
    tick();
    check("fall_c1_ground", 16'(ground), 16'd0);
    check("fall_priority_pos", 16'(pos), 16'd3);
    tick();
    check("fall_c2_ground", 16'(ground), 16'd0);
    tick();
    check("fall_c3_ground", 16'(ground), 16'd1);
    check("fall_c3_falls", 16'(falls), 16'd0);
    check("fall_c3_done", 16'(done), 16'd0);
    tick();
    check("land_falls", 16'(falls), 16'd1);
    check("land_done", 16'(done), 16'd1);
    check("land_pos", 16'(pos), 16'd3);
    set_walk(1'b0, 1'b0, 1'b0);
    aaah = 1'b0;
    tick();
    check("after_fall_ground", 16'(ground), 16'd1);
    check("after_fall_falls", 16'(falls), 16'd1);

    // Reset in the middle of a fall
    load_map(16'h0008);
    set_walk(1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    set_walk(1'b0, 1'b0, 1'b0);
    aaah = 1'b1;
    tick(); tick();
    check("midfall_done", 16'(done), 16'd0);
    check("midfall_falls", 16'(falls), 16'd1);
    #2;
    areset_n = 1'b0;
    #1;
    check("midfall_rst_pos", 16'(pos), 16'd0);
    check("midfall_rst_falls", 16'(falls), 16'd0);
    check("midfall_rst_done", 16'(done), 16'd1);
    check("midfall_rst_fallcnt", 16'(ground), 16'd0);
    aaah = 1'b0;
    tick();
    check("midfall_rst_ground", 16'(ground), 16'd1);
    check("midfall_rst_falls_hold", 16'(falls), 16'd0);
    areset_n = 1'b1;
    tick();

    // Single-cycle fall and falls saturation
    d1_load   = 1'b1;
    d1_map_in = 16'h0001;
    tick();
    d1_load = 1'b0;
    #1;
    check("d1_hole_ground", 16'(d1_ground), 16'd0);
    d1_aaah = 1'b1;
    #1;
    check("d1_first_aaah_ground", 16'(d1_ground), 16'd1);
    tick();
    check("d1_land_falls", 16'(d1_falls), 16'd1);
    check("d1_land_done", 16'(d1_done), 16'd1);
    d1_aaah = 1'b0;
    for (int i = 0; i < 254; i++) d1_fall();
    check("d1_falls_255", 16'(d1_falls), 16'd255);
    d1_fall();
    check("d1_falls_sat", 16'(d1_falls), 16'd255);
    check("d1_sat_done", 16'(d1_done), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
